// File: rtl/fused_pkg.sv
// Shared types and constants for the fused accelerator's output write-back path.
package fused_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int BYTES_PER_WORD     = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    FINISH
  } wb_state_t;

endpackage

// File: rtl/ofm_word_fifo.sv
// 32-bit first-word-fall-through FIFO holding packed output words until the
// global BRAM write port is granted.
module ofm_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [31:0]              push_data_i,
  input  logic                     pop_i,
  output logic [31:0]              pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so
  // stale entries are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ofm_writeback_unit.sv
// Packs layer-2 result bytes into little-endian 32-bit words and streams them
// to consecutive global BRAM addresses from a sampled base.
module ofm_writeback_unit
  import fused_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr_OFM,
  input  logic [31:0] size_OFM,
  input  logic        valid_layer2,
  input  logic [7:0]  data_layer2,
  output logic        ready_layer2,
  input  logic        global_wr_grant,
  output logic [31:0] wr_addr_global,
  output logic [31:0] wr_data_global,
  output logic        we_global,
  output logic        busy,
  output logic        done
);

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  wb_state_t   state_q, state_d;
  logic [31:0] base_q;
  logic [31:0] size_q;
  logic [31:0] word_index_q;
  logic [31:0] words_pushed_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] pack_q;
  logic        we_q;
  logic [31:0] wr_data_q;
  logic [31:0] wr_addr_q;

  logic [31:0]   job_words;
  logic          start_ok;
  logic          byte_fire;
  logic          word_fire;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  // The low two size bits are dropped: the job is a whole number of words.
  assign job_words    = size_q >> 2;
  assign start_ok     = start && (state_q == IDLE);
  assign ready_layer2 = (state_q == COLLECT) && (fifo_count < DEPTH_CNT);
  assign byte_fire    = valid_layer2 && ready_layer2;
  assign word_fire    = byte_fire && (byte_cnt_q == LAST_BYTE);
  assign fifo_pop     = ((state_q == COLLECT) || (state_q == DRAIN)) &&
                        !fifo_empty && global_wr_grant;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);

  assign we_global      = we_q;
  assign wr_data_global = wr_data_q;
  assign wr_addr_global = wr_addr_q;

  ofm_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (word_fire),
    .push_data_i ({data_layer2, pack_q}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (size_OFM[31:2] == '0) ? FINISH : COLLECT;
      end
      COLLECT: begin
        if (word_fire && (words_pushed_q + 32'd1 == job_words)) state_d = DRAIN;
      end
      DRAIN: begin
        if (word_index_q == job_words) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q         <= '0;
      size_q         <= '0;
      word_index_q   <= '0;
      words_pushed_q <= '0;
      byte_cnt_q     <= '0;
      pack_q         <= '0;
    end else if (start_ok) begin
      base_q         <= base_addr_OFM;
      size_q         <= size_OFM;
      word_index_q   <= '0;
      words_pushed_q <= '0;
      byte_cnt_q     <= '0;
      pack_q         <= '0;
    end else begin
      if (byte_fire) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    pack_q[7:0]   <= data_layer2;
          2'd1:    pack_q[15:8]  <= data_layer2;
          2'd2:    pack_q[23:16] <= data_layer2;
          default: ;
        endcase
      end
      if (word_fire) words_pushed_q <= words_pushed_q + 32'd1;
      if (fifo_pop)  word_index_q   <= word_index_q + 32'd1;
    end
  end

  // Write port outputs are registered; the address holds between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      we_q      <= fifo_pop;
      wr_data_q <= fifo_pop ? fifo_head : '0;
      if (fifo_pop) wr_addr_q <= base_q + word_index_q * 32'(BYTES_PER_WORD);
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!reset_n) word_fire |-> !fifo_full
  );

endmodule

// File: tb/tb_ofm_writeback_unit.sv
// Scoreboard bench for ofm_writeback_unit: expected writes are queued as bytes
// are driven and compared against the writes the monitor records.
module tb_ofm_writeback_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] size = '0;
  logic        valid = 1'b0;
  logic [7:0]  data = '0;
  logic        grant = 1'b0;
  logic        ready;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        we;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_rd = 0;
  int          done_seen = 0;
  int          acc_seen = 0;

  always #5 clk = ~clk;

  ofm_writeback_unit #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .base_addr_OFM   (base),
    .size_OFM        (size),
    .valid_layer2    (valid),
    .data_layer2     (data),
    .ready_layer2    (ready),
    .global_wr_grant (grant),
    .wr_addr_global  (waddr),
    .wr_data_global  (wdata),
    .we_global       (we),
    .busy            (busy),
    .done            (done)
  );

  always @(negedge clk) begin
    if (we) obs_q.push_back({waddr, wdata});
    if (done) done_seen++;
    if (valid && ready) acc_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [31:0] s);
    start = 1'b1;
    base  = b;
    size  = s;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    int c;
    c = 0;
    valid = 1'b1;
    data  = d;
    while (!ready && c < 200) begin
      tick();
      c++;
    end
    ok = ready;
    tick();
    valid = 1'b0;
  endtask

  // Byte i of a job carries seed+i; word k lands at b_addr + 4k.
  task automatic send_job_bytes(input logic [31:0] b_addr, input int first, input int n,
                                input logic [7:0] seed);
    logic [7:0] b;
    bit         ok;
    for (int i = first; i < first + n; i++) begin
      b = seed + 8'(i);
      if (i % 4 == 3)
        exp_q.push_back({b_addr + 32'(4 * (i / 4)), {b, b - 8'd1, b - 8'd2, b - 8'd3}});
      send_byte(b, ok);
      check("byte_accept", 64'(ok), 64'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 200) begin
      tick();
      c++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_we_off"}, {31'd0, we, wdata}, 64'd0);
    tick();
    check({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
  endtask

  task automatic score(input string tag);
    check({tag, "_nwrites"}, 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      check({tag, "_write"}, obs_q[obs_rd], exp_q.pop_front());
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int done0;
    int acc0;

    // Reset state
    repeat (2) tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(waddr), 64'd0);
    check("rst_data", 64'(wdata), 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Basic 8-byte job with grant held high
    grant = 1'b1;
    start_job(32'h100, 32'd8);
    check("t1_busy", 64'(busy), 64'd1);
    send_job_bytes(32'h100, 0, 8, 8'h01);
    wait_done("t1");
    score("t1");

    // Minimum latency: 4th byte accepted in cycle N, write visible in N+2
    start_job(32'h700, 32'd4);
    send_job_bytes(32'h700, 0, 4, 8'hC0);
    check("lat_n1_we", 64'(we), 64'd0);
    tick();
    check("lat_n2_write", {31'd0, we, waddr}, {31'd0, 1'b1, 32'h700});
    check("lat_n2_data", 64'(wdata), 64'h00000000_C3C2C1C0);
    wait_done("lat");
    score("lat");

    // Grant withheld during collect: 16 bytes fit in a 4-deep FIFO
    grant = 1'b0;
    start_job(32'h0, 32'd16);
    send_job_bytes(32'h0, 0, 16, 8'h10);
    check("t2_ready_after_job", 64'(ready), 64'd0);
    repeat (4) tick();
    check("t2_no_write", 64'(obs_q.size() - obs_rd), 64'd0);
    check("t2_busy", 64'(busy), 64'd1);
    grant = 1'b1;
    wait_done("t2");
    score("t2");

    // FIFO full stalls the byte stream until the write port is granted
    grant = 1'b0;
    start_job(32'h40, 32'd20);
    send_job_bytes(32'h40, 0, 16, 8'h20);
    valid = 1'b1;
    data  = 8'hEE;
    repeat (3) tick();
    check("t2b_full_ready", 64'(ready), 64'd0);
    check("t2b_full_busy", 64'(busy), 64'd1);
    valid = 1'b0;
    grant = 1'b1;
    send_job_bytes(32'h40, 16, 4, 8'h20);
    wait_done("t2b");
    score("t2b");

    // Zero-word job: straight to FINISH, no writes, no ready
    start_job(32'h900, 32'd3);
    check("t3_done", {61'd0, done, busy, ready}, {61'd0, 1'b1, 1'b1, 1'b0});
    tick();
    check("t3_idle", {61'd0, done, busy, ready}, 64'd0);
    score("t3");

    // size=7 -> one word; the fifth byte is refused
    acc0 = acc_seen;
    start_job(32'h300, 32'd7);
    send_job_bytes(32'h300, 0, 4, 8'h31);
    valid = 1'b1;
    data  = 8'h55;
    tick();
    check("t4_refuse", 64'(ready), 64'd0);
    wait_done("t4");
    valid = 1'b0;
    check("t4_accepted", 64'(acc_seen - acc0), 64'd4);
    score("t4");

    // start during COLLECT is ignored
    start_job(32'h500, 32'd8);
    send_job_bytes(32'h500, 0, 2, 8'h61);
    start_job(32'h900, 32'd4);
    check("t5_busy", 64'(busy), 64'd1);
    send_job_bytes(32'h500, 2, 6, 8'h61);
    wait_done("t5");
    score("t5");

    // Reset after 6 of 8 bytes
    start_job(32'h600, 32'd8);
    send_job_bytes(32'h600, 0, 6, 8'h71);
    reset_n = 1'b0;
    #1;
    check("t6_rst_ctl", {61'd0, ready, busy, done}, 64'd0);
    check("t6_rst_we_data", {31'd0, we, wdata}, 64'd0);
    check("t6_rst_addr", 64'(waddr), 64'd0);
    done0 = done_seen;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("t6_no_done", 64'(done_seen - done0), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);
    score("t6_pre");
    start_job(32'h200, 32'd4);
    send_job_bytes(32'h200, 0, 4, 8'h81);
    wait_done("t6");
    score("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
